// File: rtl/audio_capture_recorder.sv
// Microphone capture path. It pops samples from the audio input FIFO, mixes
// left/right to mono, optionally waits for a loudness trigger, decimates, and
// writes DATA_W-bit samples into an external capture RAM.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no capture; popped samples are discarded
// S_ARMED  | waiting for a sample with |mix| >= trig_level
// S_RECORD | writing one of every DECIM consumed samples
// S_DONE   | DEPTH samples written; done held high until restart/abort
module audio_capture_recorder #(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 16000,
   parameter int DATA_W = 6,
   parameter int DECIM  = 1
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic              trig_en,
   input  logic [31:0]       trig_level,
   input  logic              audio_in_available,
   input  logic [31:0]       left_channel_audio_in,
   input  logic [31:0]       right_channel_audio_in,
   output logic              read_audio_in,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count
);

   localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [DCW-1:0]  DECIM_LAST = DCW'(DECIM - 1);
   localparam logic [ADDR_W:0] LAST_CNT   = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_RECORD,
      S_DONE
   } state_t;

   state_t              state_q;
   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;
   logic                done_q;
   logic [ADDR_W:0]     count_q;
   logic [DCW-1:0]      decim_q;
   logic                trig_en_q;

   logic                pop_w;
   logic [32:0]         sum_w;
   logic [31:0]         mix_w;
   logic [31:0]         mag_w;
   logic [DATA_W-1:0]   sample_w;
   logic                trig_hit_w;
   logic                take_w;
   logic [DCW-1:0]      decim_nxt_w;
   logic                unused_lsb_w;

   // The FIFO is drained whenever it has data and we are out of reset.
   assign pop_w         = audio_in_available & resetn;
   assign read_audio_in = pop_w;

   // Mono mix, magnitude with saturation of the single unrepresentable value,
   // and truncation to the stored width (same format playback reads back).
   always_comb begin
      sum_w = {left_channel_audio_in[31], left_channel_audio_in}
            + {right_channel_audio_in[31], right_channel_audio_in};
      mix_w = sum_w[32:1];
      if (mix_w == 32'h8000_0000) begin
         mag_w = 32'h7FFF_FFFF;
      end else if (mix_w[31]) begin
         mag_w = ~mix_w + 32'd1;
      end else begin
         mag_w = mix_w;
      end
      sample_w = mix_w[31 -: DATA_W];
   end

   // The halving shifts the sum's lsb out; it is intentionally dropped.
   assign unused_lsb_w = sum_w[0];

   // A consumed sample is taken into the record path while recording, or when
   // it is the trigger sample in ARMED (that sample is itself the first write).
   always_comb begin
      trig_hit_w  = !trig_en_q || (mag_w >= trig_level);
      take_w      = pop_w && ((state_q == S_RECORD) ||
                              ((state_q == S_ARMED) && trig_hit_w));
      decim_nxt_w = (decim_q == DECIM_LAST) ? '0 : decim_q + DCW'(1);
   end

   // Capture sequencer with registered write port and status.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         count_q   <= '0;
         decim_q   <= '0;
         trig_en_q <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         if (abort) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     state_q   <= trig_en ? S_ARMED : S_RECORD;
                     trig_en_q <= trig_en;
                     done_q    <= 1'b0;
                     count_q   <= '0;
                     wr_addr_q <= '0;
                     decim_q   <= '0;
                  end
               end
               S_ARMED, S_RECORD: begin
                  if (take_w) begin
                     state_q <= S_RECORD;
                     decim_q <= decim_nxt_w;
                     if (decim_q == '0) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= count_q[ADDR_W-1:0];
                        wr_data_q <= sample_w;
                        count_q   <= count_q + 1'b1;
                        if (count_q == LAST_CNT) begin
                           state_q <= S_DONE;
                           done_q  <= 1'b1;
                        end
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign done    = done_q;
   assign count   = count_q;
   assign busy    = (state_q == S_ARMED) || (state_q == S_RECORD);

endmodule

// File: tb/tb_audio_capture_recorder.sv
// Bench for audio_capture_recorder: two instances (DEPTH=8/DECIM=1 and
// DEPTH=4/DECIM=3) share stimulus and are checked every cycle against a
// behavioural model built from sample indices and plain integer arithmetic.
module tb_audio_capture_recorder;

   localparam int AW = 4;
   localparam int DW = 6;
   localparam int M_IDLE = 0, M_WAIT = 1, M_REC = 2, M_FIN = 3;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0, abort = 1'b0, trig_en = 1'b0, avail = 1'b0;
   logic [31:0]   trig_level = '0, left = '0, right = '0;

   logic          rd_a, we_a, busy_a, done_a;
   logic [AW-1:0] addr_a;
   logic [DW-1:0] data_a;
   logic [AW:0]   cnt_a;
   logic          rd_b, we_b, busy_b, done_b;
   logic [AW-1:0] addr_b;
   logic [DW-1:0] data_b;
   logic [AW:0]   cnt_b;

   always #10 clk = ~clk;

   audio_capture_recorder #(.ADDR_W(AW), .DEPTH(8), .DATA_W(DW), .DECIM(1)) dut_a (
      .CLOCK_50(clk), .resetn(resetn), .start(start), .abort(abort),
      .trig_en(trig_en), .trig_level(trig_level), .audio_in_available(avail),
      .left_channel_audio_in(left), .right_channel_audio_in(right),
      .read_audio_in(rd_a), .wr_en(we_a), .wr_addr(addr_a), .wr_data(data_a),
      .busy(busy_a), .done(done_a), .count(cnt_a));

   audio_capture_recorder #(.ADDR_W(AW), .DEPTH(4), .DATA_W(DW), .DECIM(3)) dut_b (
      .CLOCK_50(clk), .resetn(resetn), .start(start), .abort(abort),
      .trig_en(trig_en), .trig_level(trig_level), .audio_in_available(avail),
      .left_channel_audio_in(left), .right_channel_audio_in(right),
      .read_audio_in(rd_b), .wr_en(we_b), .wr_addr(addr_b), .wr_data(data_b),
      .busy(busy_b), .done(done_b), .count(cnt_b));

   int n_vec = 0;
   int n_err = 0;

   int depth [2] = '{8, 4};
   int decim [2] = '{1, 3};
   int md_mode [2];
   int md_count[2];
   int md_addr [2];
   int md_data [2];
   int md_nrec [2];
   bit md_wr   [2];
   bit md_done [2];

   function automatic longint mix_val(logic [31:0] l, logic [31:0] r);
      return (longint'($signed(l)) + longint'($signed(r))) >>> 1;
   endfunction

   function automatic longint magn(longint m);
      longint a;
      a = (m < 0) ? -m : m;
      if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
      return a;
   endfunction

   function automatic int stored(longint m);
      return int'((m >>> (32 - DW)) & ((64'sd1 << DW) - 1));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         md_mode[d] = M_IDLE; md_count[d] = 0; md_addr[d] = 0; md_data[d] = 0;
         md_nrec[d] = 0; md_wr[d] = 1'b0; md_done[d] = 1'b0;
      end
   endtask

   task automatic check_dut(input int d, input string p, input logic rd, input logic we,
                            input logic [63:0] addr, input logic [63:0] data,
                            input logic bsy, input logic dn, input logic [63:0] cnt);
      chk({p, ".read_audio_in"}, rd, avail & resetn);
      chk({p, ".wr_en"}, we, md_wr[d]);
      chk({p, ".wr_addr"}, addr, md_addr[d]);
      chk({p, ".wr_data"}, data, md_data[d]);
      chk({p, ".busy"}, bsy, (md_mode[d] == M_WAIT) || (md_mode[d] == M_REC));
      chk({p, ".done"}, dn, md_done[d]);
      chk({p, ".count"}, cnt, md_count[d]);
   endtask

   task automatic check_all();
      if (!resetn) model_reset();
      check_dut(0, "a", rd_a, we_a, addr_a, data_a, busy_a, done_a, cnt_a);
      check_dut(1, "b", rd_b, we_b, addr_b, data_b, busy_b, done_b, cnt_b);
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      longint m, mg;
      bit pop;
      m   = mix_val(left, right);
      mg  = magn(m);
      pop = avail && resetn;
      if (!resetn) begin
         model_reset();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         md_wr[d] = 1'b0;
         if (abort) begin
            md_mode[d] = M_IDLE;
            md_done[d] = 1'b0;
         end else if (md_mode[d] == M_IDLE || md_mode[d] == M_FIN) begin
            if (start) begin
               md_mode[d]  = trig_en ? M_WAIT : M_REC;
               md_done[d]  = 1'b0;
               md_count[d] = 0;
               md_addr[d]  = 0;
               md_nrec[d]  = 0;
            end
         end else if (pop && (md_mode[d] == M_REC || mg >= longint'(trig_level))) begin
            md_mode[d] = M_REC;
            if (md_nrec[d] % decim[d] == 0) begin
               md_wr[d]   = 1'b1;
               md_addr[d] = md_count[d];
               md_data[d] = stored(m);
               md_count[d]++;
               if (md_count[d] == depth[d]) begin
                  md_mode[d] = M_FIN;
                  md_done[d] = 1'b1;
               end
            end
            md_nrec[d]++;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic te);
      trig_en = te;
      start = 1'b1;
      step();
      start = 1'b0;
      trig_en = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   initial begin
      model_reset();
      // reset values
      step();
      step();
      resetn = 1'b1;
      step();

      // 12 ramp samples: a stops after 8, b writes samples 0,3,6,9
      pulse_start(1'b0);
      for (int k = 0; k < 12; k++) begin
         avail = 1'b1;
         left  = 32'(k) << 26;
         right = 32'(k) << 26;
         step();
      end
      avail = 1'b0;
      step();
      step();
      chk("ramp.done_a", done_a, 1);
      chk("ramp.count_a", cnt_a, 8);
      chk("ramp.done_b", done_b, 1);
      chk("ramp.count_b", cnt_b, 4);

      // sign handling of the mix, restart from DONE
      pulse_start(1'b0);
      chk("restart.count_a", cnt_a, 0);
      avail = 1'b1;
      left = 32'h7FFF_FFFF; right = 32'h8000_0000;
      step();
      chk("mix_m1.data_a", data_a, 6'h3F);
      left = 32'h8000_0000; right = 32'h8000_0000;
      step();
      chk("mix_min.data_a", data_a, 6'h20);
      avail = 1'b0;
      step();

      // loudness trigger
      pulse_abort();
      trig_level = 32'h1000_0000;
      pulse_start(1'b1);
      avail = 1'b1;
      left = 32'h0FFF_FFFF; right = 32'h0FFF_FFFF;
      step();
      chk("trig_below.wr_en_a", we_a, 0);
      chk("trig_below.busy_a", busy_a, 1);
      left = 32'h1000_0000; right = 32'h1000_0000;
      step();
      chk("trig_hit.wr_en_a", we_a, 1);
      chk("trig_hit.addr_a", addr_a, 0);
      chk("trig_hit.data_a", data_a, 6'h04);
      left = 32'h0; right = 32'h0;
      step();
      chk("trig_next.addr_a", addr_a, 1);
      avail = 1'b0;
      step();

      // abort with a sample popped in the same cycle
      pulse_abort();
      pulse_start(1'b0);
      for (int k = 0; k < 3; k++) begin
         avail = 1'b1;
         left = $urandom; right = $urandom;
         step();
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      avail = 1'b0;
      chk("abort.wr_en_a", we_a, 0);
      chk("abort.busy_a", busy_a, 0);
      chk("abort.count_a", cnt_a, 3);
      step();
      pulse_start(1'b0);
      avail = 1'b1;
      left = $urandom; right = $urandom;
      step();
      chk("abort_restart.addr_a", addr_a, 0);
      avail = 1'b0;
      step();

      // randomized traffic
      for (int i = 0; i < 700; i++) begin
         avail   = ($urandom_range(0, 3) != 0);
         left    = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : 32'($urandom);
         right   = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : 32'($urandom);
         start   = ($urandom_range(0, 19) == 0);
         abort   = ($urandom_range(0, 79) == 0);
         trig_en = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: trig_level = 32'h0;
            1: trig_level = 32'h1000_0000;
            2: trig_level = 32'h6000_0000;
            default: trig_level = $urandom;
         endcase
         step();
      end
      start = 1'b0; abort = 1'b0; avail = 1'b0; trig_en = 1'b0;
      step();

      // reset asserted while a write pulse is on the port
      pulse_abort();
      pulse_start(1'b0);
      avail = 1'b1;
      left = $urandom; right = $urandom;
      step();
      step();
      chk("pre_reset.wr_en_a", we_a, 1);
      resetn = 1'b0;
      #1;
      chk("reset.read_audio_in_a", rd_a, 0);
      chk("reset.wr_en_a", we_a, 0);
      chk("reset.count_a", cnt_a, 0);
      chk("reset.addr_a", addr_a, 0);
      chk("reset.data_a", data_a, 0);
      chk("reset.busy_a", busy_a, 0);
      chk("reset.wr_en_b", we_b, 0);
      step();
      step();
      avail = 1'b0;
      resetn = 1'b1;
      step();
      pulse_start(1'b0);
      avail = 1'b1;
      left = $urandom; right = $urandom;
      step();
      avail = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
